serial_adder_nbit: RTL and testbench

- Parametrised multi-cycle successor to the fixed 4-bit combinational adder.
- Adds two NUM_BITS operands plus carry_in, CHUNK_BITS per clock, rippling a registered carry between chunks.
- Reports sum and overflow with a start/busy/done handshake.
- Sits in datapaths where a wide single-cycle ripple would break timing.

---
 rtl/serial_adder_nbit_if.sv | 23 ++
 rtl/serial_adder_nbit.sv | 160 ++++++++++++++++
 tb/tb_serial_adder_nbit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_nbit_if.sv
// Request/result bundle for serial_adder_nbit: operands and start in, result and status out.
interface serial_adder_nbit_if #(
  parameter int NUM_BITS = 16
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;
  logic                busy;
  logic                done;

  modport master (
    output start, a, b, carry_in,
    input  sum, overflow, busy, done
  );

  modport slave (
    input  start, a, b, carry_in,
    output sum, overflow, busy, done
  );
endinterface

// File: rtl/serial_adder_nbit.sv
// Multi-cycle NUM_BITS adder, CHUNK_BITS per clock with a registered inter-chunk carry.
// Optional macro SIGNED_OVERFLOW_EN selects two's-complement overflow instead of carry-out.
module serial_adder_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int CHUNK_BITS = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  serial_adder_nbit_if.slave bus
);

  localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  generate
    if ((CHUNK_BITS < 1) || ((NUM_BITS % CHUNK_BITS) != 0)) begin : g_param_check
      $fatal(1, "serial_adder_nbit: NUM_BITS must be a non-zero multiple of CHUNK_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  accept_s;
  logic                  chunk_en_s;
  logic                  finish_s;

  logic [NUM_BITS-1:0]   a_r;
  logic [NUM_BITS-1:0]   b_r;
  logic [NUM_BITS-1:0]   acc_r;
  logic                  carry_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [NUM_BITS-1:0]   sum_r;
  logic                  ovf_r;
  logic                  busy_r;
  logic                  done_r;

  logic [CHUNK_BITS:0]   chunk_s;
  logic [CHUNK_BITS-1:0] chunk_sum_s;
  logic                  chunk_cout_s;
  logic                  ovf_s;
  logic [NUM_BITS-1:0]   acc_next_s;

  // Returns {carry_out, sum} of one chunk.
  function automatic logic [CHUNK_BITS:0] chunk_add(
    input logic [CHUNK_BITS-1:0] x,
    input logic [CHUNK_BITS-1:0] y,
    input logic                  cin
  );
    chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK_BITS{1'b0}}, cin};
  endfunction

  assign chunk_s      = chunk_add(a_r[CHUNK_BITS-1:0], b_r[CHUNK_BITS-1:0], carry_r);
  assign chunk_sum_s  = chunk_s[CHUNK_BITS-1:0];
  assign chunk_cout_s = chunk_s[CHUNK_BITS];

`ifdef SIGNED_OVERFLOW_EN
  logic msb_cin_s;
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign msb_cin_s = chunk_sum_s[CHUNK_BITS-1] ^ a_r[CHUNK_BITS-1] ^ b_r[CHUNK_BITS-1];
  assign ovf_s     = msb_cin_s ^ chunk_cout_s;
`else
  assign ovf_s     = chunk_cout_s;
`endif

  // New chunks enter at the top so chunk 0 lands at bit 0 after the last shift.
  generate
    if (NUM_CHUNKS == 1) begin : g_acc_single
      assign acc_next_s = chunk_sum_s;
    end else begin : g_acc_shift
      assign acc_next_s = {chunk_sum_s, acc_r[NUM_BITS-1:CHUNK_BITS]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    chunk_en_s   = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          accept_s     = 1'b1;
          state_next_s = ADD;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADD: begin
        chunk_en_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          finish_s     = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = ADD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand shifting, carry ripple, accumulation and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_r     <= {NUM_BITS{1'b0}};
      b_r     <= {NUM_BITS{1'b0}};
      acc_r   <= {NUM_BITS{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      sum_r   <= {NUM_BITS{1'b0}};
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ADD);
      done_r <= (state_next_s == DONE);
      if (accept_s) begin
        a_r     <= bus.a;
        b_r     <= bus.b;
        carry_r <= bus.carry_in;
        acc_r   <= {NUM_BITS{1'b0}};
        cnt_r   <= {CNT_W{1'b0}};
      end else if (chunk_en_s) begin
        a_r     <= a_r >> CHUNK_BITS;
        b_r     <= b_r >> CHUNK_BITS;
        carry_r <= chunk_cout_s;
        acc_r   <= acc_next_s;
        cnt_r   <= cnt_r + CNT_W'(1);
      end
      if (finish_s) begin
        sum_r <= acc_next_s;
        ovf_r <= ovf_s;
      end
    end
  end

  assign bus.sum      = sum_r;
  assign bus.overflow = ovf_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed self-checking bench for serial_adder_nbit at NUM_BITS=16, CHUNK_BITS=4.
module tb_serial_adder_nbit;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;
  logic [15:0] prev_sum;

`ifdef SIGNED_OVERFLOW_EN
  localparam logic SIGNED_BUILD = 1'b1;
`else
  localparam logic SIGNED_BUILD = 1'b0;
`endif

  serial_adder_nbit_if #(.NUM_BITS(16)) bus ();

  serial_adder_nbit #(.NUM_BITS(16), .CHUNK_BITS(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for exactly one rising edge; returns #1 after that edge.
  task automatic pulse_start(input logic [15:0] av, input logic [15:0] bv, input logic cin);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.carry_in = cin;
    tick();
    bus.start    = 1'b0;
    bus.a        = $urandom_range(0, 65535);
    bus.b        = $urandom_range(0, 65535);
    bus.carry_in = 1'b0;
  endtask

  // Called #1 after the accepting edge: four busy cycles, then one done cycle.
  task automatic expect_result(input string tag, input logic [15:0] exp_sum, input logic exp_ovf);
    for (int i = 0; i < 4; i++) begin
      check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      check_val({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
      check_val({tag, "_hold"}, {16'd0, bus.sum}, {16'd0, prev_sum});
      tick();
    end
    check_val({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check_val({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check_val({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, exp_sum});
    check_val({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
    prev_sum = exp_sum;
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_ovf);
    pulse_start(av, bv, cin);
    expect_result(tag, exp_sum, exp_ovf);
    tick();
    check_val({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    prev_sum     = 16'h0000;
    n_rst        = 1'b0;
    bus.start    = 1'b1;
    bus.a        = $urandom_range(0, 65535);
    bus.b        = $urandom_range(0, 65535);
    bus.carry_in = 1'b1;

    // Reset held for two cycles with start asserted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_sum", {16'd0, bus.sum}, 32'd0);
      check_val("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_val("rst_done", {31'd0, bus.done}, 32'd0);
    end
    bus.start = 1'b0;
    n_rst     = 1'b1;
    tick();

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, SIGNED_BUILD ? 1'b0 : 1'b1);
    run_op("sbound", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, SIGNED_BUILD ? 1'b1 : 1'b0);
    run_op("minmin", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Start while busy must not relatch operands.
    pulse_start(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h0001;
    check_val("ign_busy0", {31'd0, bus.busy}, 32'd1);
    tick();
    check_val("ign_busy1", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check_val("ign_done", {31'd0, bus.done}, 32'd1);
    check_val("ign_sum", {16'd0, bus.sum}, 32'h0002);
    prev_sum = 16'h0002;

    // Back-to-back: start presented during the DONE cycle.
    pulse_start(16'h0003, 16'h0004, 1'b0);
    check_val("b2b_nodone", {31'd0, bus.done}, 32'd0);
    expect_result("b2b", 16'h0007, 1'b0);
    tick();

    // Asynchronous reset two ADD cycles into an operation.
    pulse_start(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    check_val("mrst_sum", {16'd0, bus.sum}, 32'd0);
    check_val("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("mrst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    prev_sum = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("mrst_nopulse", {31'd0, bus.done}, 32'd0);
      check_val("mrst_idle", {31'd0, bus.busy}, 32'd0);
    end
    run_op("post", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
